// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, direct-mapped BTB with 2-bit
// saturating counters, and the IF/ID load/flush controls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int unsigned BTB_ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic        phit_o,
  output logic [31:0] bp_ao,
  output logic        pipe_en_o,
  output logic        pipe_flush_o
);

  localparam int unsigned IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = 32 - IW - 2;

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;

  logic          btb_valid  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]   btb_target [BTB_ENTRIES];
  logic [1:0]    btb_cnt    [BTB_ENTRIES];

  logic [IW-1:0] rd_idx;
  logic [TW-1:0] rd_tag;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] wr_tag;
  logic          rd_hit;
  logic          upd_hit;

  // Low address bits are word-aligned and intentionally dropped.
  logic          unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

  assign rd_idx   = pc[IW+1:2];
  assign rd_tag   = pc[31:IW+2];
  assign wr_idx   = upd_pc[IW+1:2];
  assign wr_tag   = upd_pc[31:IW+2];
  assign pc_plus4 = pc + 32'd4;

  assign imemREN      = nRST;
  assign imemaddr     = pc;
  assign instr_o      = imemload;
  assign npc_o        = pc_plus4;
  assign pipe_flush_o = redirect;
  assign pipe_en_o    = ihit & ~stall & ~redirect;

  // BTB lookup on the current PC, using contents before any same-cycle training.
  always_comb begin
    rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    phit_o = rd_hit && btb_cnt[rd_idx][1];
    bp_ao  = phit_o ? btb_target[rd_idx] : 32'd0;
  end

  // Next PC selection: redirect wins, then an accepted fetch advances.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (ihit && !stall) begin
      pc_next = phit_o ? {bp_ao[31:2], 2'b00} : pc_plus4;
    end
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc <= pc_next;
    end
  end

  assign upd_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  // BTB training from resolved branches; taken misses allocate weakly-taken.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[IW'(i)]  <= 1'b0;
        btb_tag[IW'(i)]    <= '0;
        btb_target[IW'(i)] <= 32'd0;
        btb_cnt[IW'(i)]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          btb_target[wr_idx] <= upd_target;
          if (btb_cnt[wr_idx] != 2'b11) begin
            btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'd1;
          end
        end else if (btb_cnt[wr_idx] != 2'b00) begin
          btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= upd_target;
        btb_cnt[wr_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, mid-run reset sequence,
// and randomized traffic checked against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h00000000;
  localparam int unsigned NENT   = 8;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_o;
  logic [31:0] npc_o;
  logic        phit_o;
  logic [31:0] bp_ao;
  logic        pipe_en_o;
  logic        pipe_flush_o;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RST_PC), .BTB_ENTRIES(NENT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .imemREN(imemREN), .imemaddr(imemaddr),
    .instr_o(instr_o), .npc_o(npc_o), .phit_o(phit_o), .bp_ao(bp_ao),
    .pipe_en_o(pipe_en_o), .pipe_flush_o(pipe_flush_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: a map from index to {tag, target, counter};
  // an absent key is an invalid entry.
  typedef struct {
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        mbtb [int];
  logic [31:0] m_pc;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NENT);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (4 * NENT);
  endfunction

  function automatic void m_look(output logic ph, output logic [31:0] tgt);
    int i;
    i   = m_idx(m_pc);
    ph  = 1'b0;
    tgt = 32'd0;
    if (mbtb.exists(i) && mbtb[i].tag == m_tag(m_pc) && mbtb[i].ctr >= 2) begin
      ph  = 1'b1;
      tgt = mbtb[i].tgt;
    end
  endfunction

  task automatic m_update();
    logic        ph;
    logic [31:0] tgt;
    int          i;
    if (!nRST) begin
      mbtb.delete();
      m_pc = RST_PC;
    end else begin
      m_look(ph, tgt);
      if (redirect)          m_pc = redirect_pc & ~32'd3;
      else if (ihit && !stall) m_pc = ph ? (tgt & ~32'd3) : m_pc + 32'd4;
      if (upd_en) begin
        i = m_idx(upd_pc);
        if (mbtb.exists(i) && mbtb[i].tag == m_tag(upd_pc)) begin
          if (upd_taken) begin
            mbtb[i].tgt = upd_target;
            if (mbtb[i].ctr < 3) mbtb[i].ctr++;
          end else if (mbtb[i].ctr > 0) begin
            mbtb[i].ctr--;
          end
        end else if (upd_taken) begin
          mbtb[i] = '{tag: m_tag(upd_pc), tgt: upd_target, ctr: 2};
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge CLK);
    m_update();
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; stall = 0; redirect = 0; redirect_pc = 0;
    upd_en = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    imemload = $urandom;
  endtask

  typedef struct {
    logic        ihit, stall, redir;
    logic [31:0] rpc;
    logic        upd, utk;
    logic [31:0] upc, utgt;
    logic [31:0] e_addr;
    logic        e_phit;
    logic [31:0] e_bp;
    logic        e_en, e_fl;
  } vec_t;

  function automatic vec_t mk(logic ih, logic st, logic rd, logic [31:0] rpc,
                              logic up, logic tk, logic [31:0] upc, logic [31:0] utgt,
                              logic [31:0] ea, logic eph, logic [31:0] ebp,
                              logic een, logic efl);
    vec_t v;
    v = '{ihit: ih, stall: st, redir: rd, rpc: rpc, upd: up, utk: tk, upc: upc,
          utgt: utgt, e_addr: ea, e_phit: eph, e_bp: ebp, e_en: een, e_fl: efl};
    return v;
  endfunction

  vec_t        tbl [$];
  logic [31:0] pcs [8];

  initial begin
    pcs = '{32'h40, 32'h44, 32'h48, 32'h60, 32'h100, 32'h200, 32'hFFFFFFF8, 32'hFFFFFFFC};

    //            ih st rd rpc          up tk upc     utgt     addr          ph bp      en fl
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h0,        0, 0,      1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h4,        0, 0,      1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h8,        0, 0,      1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           1, 1, 32'h40, 32'h100, 32'hC,        0, 0,      1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40,      0, 0, 0,      0,       32'h10,       0, 0,      0, 1));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h40,       1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,           1, 0, 32'h40, 0,       32'h100,      0, 0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,           1, 0, 32'h40, 0,       32'h100,      0, 0,      0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40,      0, 0, 0,      0,       32'h100,      0, 0,      0, 1));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h40,       0, 0,      1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h203,     0, 0, 0,      0,       32'h44,       0, 0,      0, 1));
    tbl.push_back(mk(0, 1, 0, 0,           0, 0, 0,      0,       32'h200,      0, 0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0,           0, 0, 0,      0,       32'h200,      0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h200,      0, 0,      1, 0));
    tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0,     0,       32'h204,      0, 0,      0, 1));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'hFFFFFFFC, 0, 0,      1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h48,      0, 0, 0,      0,       32'h0,        0, 0,      0, 1));
    tbl.push_back(mk(0, 0, 0, 0,           1, 1, 32'h48, 32'h300, 32'h48,       0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h48,       1, 32'h300, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,      0,       32'h300,      0, 0,      1, 0));

    // Reset state.
    idle_inputs();
    nRST = 0;
    tick();
    tick();
    chk("rst_addr",  imemaddr, RST_PC);
    chk("rst_npc",   npc_o,    RST_PC + 32'd4);
    chk("rst_phit",  32'(phit_o), 32'd0);
    chk("rst_bp",    bp_ao,    32'd0);
    chk("rst_ren",   32'(imemREN), 32'd0);
    nRST = 1;

    // Directed table.
    foreach (tbl[k]) begin
      ihit = tbl[k].ihit; stall = tbl[k].stall; redirect = tbl[k].redir;
      redirect_pc = tbl[k].rpc; upd_en = tbl[k].upd; upd_taken = tbl[k].utk;
      upd_pc = tbl[k].upc; upd_target = tbl[k].utgt; imemload = $urandom;
      #1;
      chk($sformatf("v%0d_addr", k),  imemaddr, tbl[k].e_addr);
      chk($sformatf("v%0d_npc", k),   npc_o,    tbl[k].e_addr + 32'd4);
      chk($sformatf("v%0d_phit", k),  32'(phit_o), 32'(tbl[k].e_phit));
      chk($sformatf("v%0d_bp", k),    bp_ao,    tbl[k].e_bp);
      chk($sformatf("v%0d_en", k),    32'(pipe_en_o), 32'(tbl[k].e_en));
      chk($sformatf("v%0d_fl", k),    32'(pipe_flush_o), 32'(tbl[k].e_fl));
      chk($sformatf("v%0d_instr", k), instr_o,  imemload);
      chk($sformatf("v%0d_ren", k),   32'(imemREN), 32'd1);
      tick();
    end

    // Reset mid-operation discards same-cycle redirect and training.
    idle_inputs();
    nRST = 0; redirect = 1; redirect_pc = 32'h80;
    upd_en = 1; upd_pc = 32'h80; upd_target = 32'h500; upd_taken = 1;
    tick();
    idle_inputs();
    nRST = 1;
    #1;
    chk("mrst_addr", imemaddr, RST_PC);
    chk("mrst_npc",  npc_o, RST_PC + 32'd4);
    redirect = 1; redirect_pc = 32'h48;
    tick();
    redirect = 0;
    #1;
    chk("mrst_addr48", imemaddr, 32'h48);
    chk("mrst_phit48", 32'(phit_o), 32'd0);
    redirect = 1; redirect_pc = 32'h80;
    tick();
    redirect = 0;
    #1;
    chk("mrst_phit80", 32'(phit_o), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic        eph;
      logic [31:0] etg;
      nRST        = ($urandom_range(0, 59) != 0);
      ihit        = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      upd_en      = ($urandom_range(0, 2) == 0);
      upd_pc      = pcs[$urandom_range(0, 7)];
      upd_target  = pcs[$urandom_range(0, 7)];
      upd_taken   = 1'($urandom_range(0, 1));
      imemload    = $urandom;
      #1;
      m_look(eph, etg);
      chk("rnd_addr",  imemaddr, m_pc);
      chk("rnd_npc",   npc_o,    m_pc + 32'd4);
      chk("rnd_phit",  32'(phit_o), 32'(eph));
      chk("rnd_bp",    bp_ao,    etg);
      chk("rnd_en",    32'(pipe_en_o), 32'(ihit && !stall && !redirect));
      chk("rnd_fl",    32'(pipe_flush_o), 32'(redirect));
      chk("rnd_instr", instr_o,  imemload);
      chk("rnd_ren",   32'(imemREN), 32'(nRST));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, 8, direct-mapped branch target buffer depth; power of two; index width IW = log2(BTB_ENTRIES).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 nRST  in  1  reset, synchronous and active-low.
REQ-005 ihit  in  1  instruction cache returned imemload for imemaddr this cycle.
REQ-006 imemload  in  32  instruction word from instruction cache.
REQ-007 stall  in  1  hazard unit freeze of PC and IF/ID.
REQ-008 redirect  in  1  EX-stage mispredict or jump correction.
REQ-009 redirect_pc  in  32  corrected fetch address.
REQ-010 upd_en  in  1  BTB training request from EX for a resolved branch.
REQ-011 upd_pc  in  32  PC of resolved branch.
REQ-012 upd_target  in  32  resolved branch target.
REQ-013 upd_taken  in  1  resolved branch direction.
REQ-014 imemREN  out  1  instruction read enable.
REQ-015 imemaddr  out  32  current PC.
REQ-016 instr_o  out  32  instruction to IF/ID.
REQ-017 npc_o  out  32  PC+4 to IF/ID.
REQ-018 phit_o  out  1  predicted taken for this instruction.
REQ-019 bp_ao  out  32  predicted target to IF/ID.
REQ-020 pipe_en_o  out  1  IF/ID load enable.
REQ-021 pipe_flush_o  out  1  IF/ID flush.

Function
REQ-022 PC register 32 bits; PC[1:0] held 0; redirect_pc[1:0] ignored.
REQ-023 imemaddr = PC; imemREN = 1 whenever nRST = 1.
REQ-024 BTB entry: valid, tag = PC[31:IW+2], target[31:0], 2-bit saturating counter; index = PC[IW+1:2].
REQ-025 Lookup combinational on current PC: hit = valid & tag match; phit_o = hit & counter[1]; bp_ao = phit_o ? entry target : 0.
REQ-026 Predicted next PC = phit_o ? target : PC+4; PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-027 PC update priority: redirect -> PC <= redirect_pc; else ihit & !stall -> PC <= predicted next PC; else PC holds.
REQ-028 instr_o = imemload, npc_o = PC+4, combinational.
REQ-029 pipe_flush_o = redirect; pipe_en_o = ihit & !stall & !redirect.
REQ-030 Training on upd_en, entry at upd_pc index: tag hit -> counter +1 if upd_taken (saturate 3), -1 if not (saturate 0); target <= upd_target when upd_taken.
REQ-031 Training tag miss: upd_taken -> allocate (valid 1, tag, target, counter 2'b10), overwriting any occupant; !upd_taken -> no change.
REQ-032 Training occurs regardless of stall, ihit, redirect.
REQ-033 Lookup and training on same index in same cycle: lookup uses pre-update contents; update visible next cycle.
REQ-034 stall with no ihit: PC, BTB lookup outputs stable; pipe_en_o = 0.

Reset
REQ-035 nRST = 0 at rising edge: PC <= RESET_PC, all BTB valid <= 0, counters <= 2'b01, targets/tags <= 0; takes priority over redirect and upd_en.
REQ-036 Reset asserted mid-operation discards pending redirect and training that cycle; first fetch after release is RESET_PC.
REQ-037 During reset outputs are combinational from reset state: phit_o = 0, bp_ao = 0, npc_o = RESET_PC+4 after first reset edge.

Verification
REQ-038 Reset, ihit = 1 every cycle, no branches -> imemaddr 0,4,8,12; pipe_en_o = 1; phit_o = 0.
REQ-039 upd_en, upd_pc = 0x40, upd_taken = 1, upd_target = 0x100; then fetch 0x40 -> phit_o = 1, bp_ao = 0x100, next PC = 0x100.
REQ-040 Same entry trained not-taken twice -> counter 10->01->00; fetch 0x40 -> phit_o = 0, next PC = 0x44.
REQ-041 redirect = 1 with stall = 1, redirect_pc = 0x203 -> PC = 0x200, pipe_flush_o = 1, pipe_en_o = 0.
REQ-042 PC = 0xFFFFFFFC, BTB miss, ihit -> npc_o = 0, next PC = 0.
REQ-043 Training and lookup on 0x40 same cycle, entry invalid -> phit_o = 0 that cycle; refetch 0x40 -> phit_o = 1.
